// File: rtl/approx_err_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : approx_err_pkg
//  Description : Shared types and width helpers for the approximate-adder
//                error monitor (state encoding, error/square widths).
//  Revision    : 1.0  initial release
// ============================================================================
package approx_err_pkg;

  // Monitor control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Signed error width: difference of two (W+1)-bit unsigned values
  function automatic int err_w(input int w);
    return w + 2;
  endfunction

  // Squared magnitude width: (W+1) x (W+1) bits
  function automatic int sq_w(input int w);
    return 2 * w + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/approx_err_monitor_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : approx_err_monitor_if
//  Description : Sample-in / result-out bundle for the error monitor.
//                master = stimulus/consumer side, slave = monitor side.
//  Revision    : 1.0  initial release
// ============================================================================
interface approx_err_monitor_if #(
  parameter int W     = 16,
  parameter int ACC_W = 48,
  parameter int CNT_W = 9
) ();

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in1;
  logic [W-1:0]     in2;
  logic [W:0]       approx_sum;
  logic             busy;
  logic             res_valid;
  logic             res_ack;
  logic [ACC_W-1:0] sse;
  logic             sse_sat;
  logic [W:0]       max_abs_err;
  logic [CNT_W-1:0] err_count;

  modport master (
    output start, in_valid, in1, in2, approx_sum, res_ack,
    input  in_ready, busy, res_valid, sse, sse_sat, max_abs_err, err_count
  );

  modport slave (
    input  start, in_valid, in1, in2, approx_sum, res_ack,
    output in_ready, busy, res_valid, sse, sse_sat, max_abs_err, err_count
  );

endinterface
`default_nettype wire

// File: rtl/approx_err_square.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : approx_err_square
//  Description : Two-stage error datapath. S1 forms the exact sum and the
//                signed error of the approximate sum; S2 produces |err| and
//                |err|^2. A valid bit travels alongside each stage.
//  Revision    : 1.0  initial release
// ============================================================================
module approx_err_square
  import approx_err_pkg::*;
#(
  parameter  int W    = 16,
  localparam int SQ_W = sq_w(W)
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            in_accept,
  input  wire logic [W-1:0]    in1,
  input  wire logic [W-1:0]    in2,
  input  wire logic [W:0]      approx_sum,
  output logic                 s2_valid,
  output logic [W:0]           s2_abs_err,
  output logic [SQ_W-1:0]      s2_sq,
  output logic                 pipe_busy
);

  localparam int ERR_W = err_w(W);

  logic                    s1_valid_q, s1_valid_d;
  logic signed [ERR_W-1:0] s1_err_q,   s1_err_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [W:0]              s2_abs_q,   s2_abs_d;
  logic [SQ_W-1:0]         s2_sq_q,    s2_sq_d;
  logic [W:0]              exact;
  logic [W:0]              s1_abs;

  // Next-state for both stages; payload holds when its stage is not loaded
  always_comb begin
    exact      = {1'b0, in1} + {1'b0, in2};
    s1_valid_d = in_accept;
    s1_err_d   = s1_err_q;
    if (in_accept) begin
      s1_err_d = $signed({1'b0, approx_sum}) - $signed({1'b0, exact});
    end

    // |err| always fits in W+1 bits, so the truncating cast is lossless
    s1_abs = s1_err_q[ERR_W-1] ? (W+1)'(-s1_err_q) : s1_err_q[W:0];

    s2_valid_d = s1_valid_q;
    s2_abs_d   = s2_abs_q;
    s2_sq_d    = s2_sq_q;
    if (s1_valid_q) begin
      s2_abs_d = s1_abs;
      s2_sq_d  = SQ_W'(s1_abs) * SQ_W'(s1_abs);
    end
  end

  // Pipeline registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_abs_q   <= '0;
      s2_sq_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_abs_q   <= s2_abs_d;
      s2_sq_q    <= s2_sq_d;
    end
  end

  assign s2_valid   = s2_valid_q;
  assign s2_abs_err = s2_abs_q;
  assign s2_sq      = s2_sq_q;
  assign pipe_busy  = s1_valid_q | s2_valid_q;

endmodule
`default_nettype wire

// File: rtl/approx_err_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : approx_err_monitor
//  Description : Windowed error statistics (SSE, max |err|, error count) for
//                an approximate W-bit adder. Collects SAMPLES samples, drains
//                the datapath, then holds results until acknowledged.
//  Revision    : 1.0  initial release
// ============================================================================
module approx_err_monitor
  import approx_err_pkg::*;
#(
  parameter int W       = 16,
  parameter int SAMPLES = 256,
  parameter int ACC_W   = 48,
  parameter int CNT_W   = $clog2(SAMPLES + 1)
) (
  input wire logic             clk,
  input wire logic             rst_n,
  approx_err_monitor_if.slave  bus
);

  localparam int SQ_W  = sq_w(W);
  // One spare bit above the wider operand so the add never wraps
  localparam int SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
  localparam logic [SUM_W-1:0] SSE_MAX = SUM_W'({ACC_W{1'b1}});

  state_e           state_q, state_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [ACC_W-1:0] sse_q, sse_d;
  logic             sse_sat_q, sse_sat_d;
  logic [W:0]       max_q, max_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             in_ready;
  logic             accept;
  logic             s2_valid;
  logic [W:0]       s2_abs_err;
  logic [SQ_W-1:0]  s2_sq;
  logic             pipe_busy;
  logic [SUM_W-1:0] sse_sum;

  assign in_ready = (state_q == RUN) && (acc_cnt_q < CNT_W'(SAMPLES));
  assign accept   = bus.in_valid && in_ready;

  approx_err_square #(
    .W (W)
  ) u_square (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_accept  (accept),
    .in1        (bus.in1),
    .in2        (bus.in2),
    .approx_sum (bus.approx_sum),
    .s2_valid   (s2_valid),
    .s2_abs_err (s2_abs_err),
    .s2_sq      (s2_sq),
    .pipe_busy  (pipe_busy)
  );

  // Window control plus statistic accumulation from the datapath output
  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    sse_d     = sse_q;
    sse_sat_d = sse_sat_q;
    max_d     = max_q;
    err_cnt_d = err_cnt_q;
    sse_sum   = SUM_W'(sse_q) + SUM_W'(s2_sq);

    if (s2_valid) begin
      if (sse_sum > SSE_MAX) begin
        sse_d     = {ACC_W{1'b1}};
        sse_sat_d = 1'b1;
      end else begin
        sse_d = sse_sum[ACC_W-1:0];
      end
      if (s2_abs_err > max_q) begin
        max_d = s2_abs_err;
      end
      if (s2_abs_err != '0) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          acc_cnt_d = '0;
          sse_d     = '0;
          sse_sat_d = 1'b0;
          max_d     = '0;
          err_cnt_d = '0;
        end
      end
      RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
          if (acc_cnt_q == CNT_W'(SAMPLES - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!pipe_busy) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // start is deliberately not looked at here: ack always wins
        if (bus.res_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and accumulator registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_cnt_q <= '0;
      sse_q     <= '0;
      sse_sat_q <= 1'b0;
      max_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      sse_q     <= sse_d;
      sse_sat_q <= sse_sat_d;
      max_q     <= max_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.busy        = (state_q == RUN) || (state_q == DRAIN);
  assign bus.res_valid   = (state_q == DONE);
  assign bus.sse         = sse_q;
  assign bus.sse_sat     = sse_sat_q;
  assign bus.max_abs_err = max_q;
  assign bus.err_count   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_approx_err_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_approx_err_monitor
//  Description : Directed + randomized bench for approx_err_monitor with a
//                window-level arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_approx_err_monitor;

  localparam int W         = 16;
  localparam int A_SAMPLES = 4;
  localparam int A_ACC     = 48;
  localparam int A_CNT     = $clog2(A_SAMPLES + 1);
  localparam int B_SAMPLES = 2;
  localparam int B_ACC     = 8;
  localparam int B_CNT     = $clog2(B_SAMPLES + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  approx_err_monitor_if #(.W(W), .ACC_W(A_ACC), .CNT_W(A_CNT)) ia ();
  approx_err_monitor_if #(.W(W), .ACC_W(B_ACC), .CNT_W(B_CNT)) ib ();

  approx_err_monitor #(.W(W), .SAMPLES(A_SAMPLES), .ACC_W(A_ACC), .CNT_W(A_CNT))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  approx_err_monitor #(.W(W), .SAMPLES(B_SAMPLES), .ACC_W(B_ACC), .CNT_W(B_CNT))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  int total = 0;
  int bad   = 0;

  // Reference model state for the current window
  longint m_sse;
  longint m_max;
  int     m_cnt;
  int     m_acc;
  bit     m_sat;

  function automatic void m_clear();
    m_sse = 0; m_max = 0; m_cnt = 0; m_acc = 0; m_sat = 1'b0;
  endfunction

  function automatic void m_add(input longint a, input longint b, input longint s, input int accw);
    longint err, ab, sq, lim;
    err = s - (a + b);
    ab  = (err < 0) ? -err : err;
    sq  = ab * ab;
    lim = (longint'(1) <<< accw) - 1;
    if (m_sse + sq > lim) begin
      m_sse = lim;
      m_sat = 1'b1;
    end else begin
      m_sse = m_sse + sq;
    end
    if (ab > m_max) m_max = ab;
    if (ab != 0) m_cnt++;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    m_clear();
    check("a_busy_run", ia.busy, 1);
    check("a_ready_run", ia.in_ready, 1);
  endtask

  task automatic send_a(input longint a, input longint b, input longint s);
    bit exp_rdy;
    exp_rdy     = (m_acc < A_SAMPLES);
    ia.in1      = a[W-1:0];
    ia.in2      = b[W-1:0];
    ia.approx_sum = s[W:0];
    ia.in_valid = 1'b1;
    check("a_in_ready", ia.in_ready, exp_rdy);
    if (exp_rdy) begin
      m_add(a, b, s, A_ACC);
      m_acc++;
    end
    tick();
    ia.in_valid = 1'b0;
  endtask

  task automatic wait_res_a(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (ia.res_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    check(tag, lat, exp_lat);
  endtask

  task automatic chk_res_a(input string tag);
    check({tag, "_sse"}, ia.sse, m_sse);
    check({tag, "_sat"}, ia.sse_sat, m_sat);
    check({tag, "_max"}, ia.max_abs_err, m_max);
    check({tag, "_cnt"}, ia.err_count, m_cnt);
    check({tag, "_res_valid"}, ia.res_valid, 1);
    check({tag, "_busy"}, ia.busy, 0);
    check({tag, "_ready"}, ia.in_ready, 0);
  endtask

  task automatic ack_a();
    ia.res_ack = 1'b1;
    tick();
    ia.res_ack = 1'b0;
    check("a_ack_res_valid", ia.res_valid, 0);
  endtask

  task automatic rand_sample(output longint a, output longint b, output longint s);
    longint ex;
    int mode;
    a    = $urandom_range(0, 65535);
    b    = $urandom_range(0, 65535);
    ex   = a + b;
    mode = $urandom_range(0, 3);
    if (mode == 0) s = ex;
    else if (mode == 3) s = $urandom_range(0, 131071);
    else begin
      s = ex + $urandom_range(0, 40) - 20;
      if (s < 0) s = 0;
      if (s > 131071) s = 131071;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    longint a, b, s;
    int guard;
    ia.start = 0; ia.in_valid = 0; ia.in1 = 0; ia.in2 = 0; ia.approx_sum = 0; ia.res_ack = 0;
    ib.start = 0; ib.in_valid = 0; ib.in1 = 0; ib.in2 = 0; ib.approx_sum = 0; ib.res_ack = 0;
    m_clear();

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", ia.in_ready, 0);
    check("rst_busy", ia.busy, 0);
    check("rst_res_valid", ia.res_valid, 0);
    check("rst_sse", ia.sse, 0);
    check("rst_sat", ia.sse_sat, 0);
    check("rst_max", ia.max_abs_err, 0);
    check("rst_cnt", ia.err_count, 0);
    rst_n = 1'b1;
    tick();
    check("idle_ready", ia.in_ready, 0);

    // Exact sums: no error at all
    start_a();
    send_a(5, 7, 12);
    send_a(100, 200, 300);
    send_a(65535, 65535, 131070);
    send_a(0, 0, 0);
    wait_res_a("t1_latency", 3);
    chk_res_a("t1");
    check("t1_sse_zero", ia.sse, 0);
    ack_a();
    check("t1_idle_busy", ia.busy, 0);

    // Directed errors +1, -3, 0, +2
    start_a();
    send_a(0, 0, 1);
    send_a(3, 3, 3);
    send_a(10, 2, 12);
    send_a(4, 4, 10);
    wait_res_a("t2_latency", 3);
    chk_res_a("t2");
    check("t2_sse_14", ia.sse, 14);
    check("t2_max_3", ia.max_abs_err, 3);
    check("t2_cnt_3", ia.err_count, 3);

    // Results held while unacknowledged; start is ignored in DONE
    ia.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_sse", ia.sse, 14);
      check("hold_valid", ia.res_valid, 1);
      check("hold_cnt", ia.err_count, 3);
    end
    ia.res_ack = 1'b1;
    tick();
    ia.start = 1'b0;
    ia.res_ack = 1'b0;
    check("ackstart_valid", ia.res_valid, 0);
    check("ackstart_busy", ia.busy, 0);
    repeat (3) tick();
    check("ackstart_no_window_busy", ia.busy, 0);
    check("ackstart_no_window_ready", ia.in_ready, 0);

    // Backpressure: valid held for 6 cycles, only the first 4 count
    start_a();
    for (int i = 0; i < 6; i++) begin
      rand_sample(a, b, s);
      send_a(a, b, s);
    end
    wait_res_a("bp_latency", 1);
    chk_res_a("bp");
    ack_a();

    // Randomized windows with idle gaps
    for (int w = 0; w < 5; w++) begin
      start_a();
      guard = 0;
      while (m_acc < A_SAMPLES && guard < 100) begin
        guard++;
        if ($urandom_range(0, 2) == 0) tick();
        else begin
          rand_sample(a, b, s);
          send_a(a, b, s);
        end
      end
      check("rnd_guard", guard < 100, 1);
      wait_res_a("rnd_latency", 3);
      chk_res_a("rnd");
      ack_a();
    end

    // Saturation on the narrow accumulator: two errors of +16
    ib.start = 1'b1;
    tick();
    ib.start = 1'b0;
    ib.in_valid = 1'b1;
    ib.in1 = 1; ib.in2 = 1; ib.approx_sum = 18;
    check("b_ready0", ib.in_ready, 1);
    tick();
    ib.in1 = 2; ib.in2 = 3; ib.approx_sum = 21;
    check("b_ready1", ib.in_ready, 1);
    tick();
    ib.in_valid = 1'b0;
    guard = 0;
    while (ib.res_valid !== 1'b1 && guard < 10) begin
      tick();
      guard++;
    end
    check("b_latency", guard, 3);
    check("b_sse", ib.sse, 255);
    check("b_sat", ib.sse_sat, 1);
    check("b_max", ib.max_abs_err, 16);
    check("b_cnt", ib.err_count, 2);
    ib.res_ack = 1'b1;
    tick();
    ib.res_ack = 1'b0;
    check("b_ack", ib.res_valid, 0);

    // Asynchronous reset mid-window
    start_a();
    send_a(1, 1, 9);
    send_a(50, 50, 90);
    tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", ia.busy, 0);
    check("arst_ready", ia.in_ready, 0);
    check("arst_valid", ia.res_valid, 0);
    check("arst_sse", ia.sse, 0);
    check("arst_max", ia.max_abs_err, 0);
    check("arst_cnt", ia.err_count, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fresh window after reset reports only its own samples
    start_a();
    send_a(1, 1, 5);
    send_a(7, 8, 15);
    send_a(0, 0, 0);
    send_a(9, 9, 18);
    wait_res_a("post_rst_latency", 3);
    chk_res_a("post_rst");
    check("post_rst_sse_9", ia.sse, 9);
    ack_a();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
